// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key schedule types, constants and round-constant lookup
package aes_pkg;

    localparam int KEY_W      = 128;
    localparam int NUM_ROUNDS = 10;
    localparam int EXP_KEY_W  = 1408;
    localparam int WORD_W     = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Entry 0 is unused so the table can be indexed by round number directly.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon_of(input logic [3:0] round);
        logic [7:0] rc;
        rc = 8'h00;
        if ((round >= 4'd1) && (round <= 4'd10)) begin
            rc = RCON[round];
        end
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box lookup
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Pure table lookup; no state.
    always_comb begin
        o_byte = SBOX[i_byte];
    end

endmodule

// File: rtl/aes_key_expansion_seq.sv
// rtl/aes_key_expansion_seq.sv - iterative AES-128 key schedule, one round key per clock
module aes_key_expansion_seq
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic                              clk,
    input  logic                              n_rst,
    input  logic                              start,
    input  logic [KEY_W-1:0]                  key_in,
    output logic [(NUM_ROUNDS+1)*KEY_W-1:0]   exp_key,
    output logic                              busy,
    output logic                              key_valid
);

    localparam int         EXP_W      = (NUM_ROUNDS + 1) * KEY_W;
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_cnt;
    logic [KEY_W-1:0]     r_prev;
    logic [EXP_W-1:0]     r_exp_key;

    logic                 w_accept;
    logic                 w_step;
    logic                 w_last;

    word_t                w_w0;
    word_t                w_w1;
    word_t                w_w2;
    word_t                w_w3;
    word_t                w_rot;
    word_t                w_sub;
    word_t                w_t;
    word_t                w_n0;
    word_t                w_n1;
    word_t                w_n2;
    word_t                w_n3;
    logic [KEY_W-1:0]     w_next_key;

    // Split the previous round key into words (w0 most significant) and rotate w3 left one byte.
    always_comb begin
        w_w0  = r_prev[127:96];
        w_w1  = r_prev[95:64];
        w_w2  = r_prev[63:32];
        w_w3  = r_prev[31:0];
        w_rot = {w_w3[23:0], w_w3[31:24]};
    end

    // SubWord: one S-box per byte of the rotated word.
    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_rot[8*g +: 8]),
            .o_byte (w_sub[8*g +: 8])
        );
    end

    // Round-key chain: each new word folds in the previous new word.
    always_comb begin
        w_t        = w_sub ^ {rcon_of(r_cnt), 24'h000000};
        w_n0       = w_w0 ^ w_t;
        w_n1       = w_w1 ^ w_n0;
        w_n2       = w_w2 ^ w_n1;
        w_n3       = w_w3 ^ w_n2;
        w_next_key = {w_n0, w_n1, w_n2, w_n3};
    end

    // Next-state decode; start is only honoured outside EXPAND, illegal encodings fall back to IDLE.
    always_comb begin
        w_next_state = IDLE;
        w_accept     = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = EXPAND;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXPAND: begin
                w_step = 1'b1;
                if (r_cnt >= LAST_ROUND) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end else begin
                    w_next_state = EXPAND;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = EXPAND;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Round counter: the round being generated this cycle; cleared once the schedule completes.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'd1;
        end else if (w_step) begin
            if (w_last) begin
                r_cnt <= 4'd0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Expanded-key store: load slot 0 and clear the rest on start, then fill slot r_cnt each EXPAND cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_prev    <= '0;
            r_exp_key <= '0;
        end else if (w_accept) begin
            r_prev    <= key_in;
            r_exp_key <= {key_in, {(EXP_W-KEY_W){1'b0}}};
        end else if (w_step) begin
            r_prev <= w_next_key;
            for (int i = 1; i <= NUM_ROUNDS; i++) begin
                if (r_cnt == 4'(i)) begin
                    r_exp_key[(NUM_ROUNDS-i)*KEY_W +: KEY_W] <= w_next_key;
                end
            end
        end
    end

    assign exp_key   = r_exp_key;
    assign busy      = (r_state == EXPAND);
    assign key_valid = (r_state == DONE);

endmodule

// File: tb/tb_aes_key_expansion_seq.sv
// tb/tb_aes_key_expansion_seq.sv - self-checking bench for aes_key_expansion_seq
module tb_aes_key_expansion_seq;

    logic            clk = 1'b0;
    logic            n_rst = 1'b0;
    logic            start = 1'b0;
    logic [127:0]    key_in = '0;
    logic [1407:0]   exp_key;
    logic            busy;
    logic            key_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [256];

    logic [1407:0] m_sched  = '0;
    logic          m_active = 1'b0;
    int            m_cnt    = 0;

    aes_key_expansion_seq dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .key_in    (key_in),
        .exp_key   (exp_key),
        .busy      (busy),
        .key_valid (key_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1407:0] act, input logic [1407:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 word-recurrence key expansion, 44 words packed round key 0 first.
    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1407:0] r;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = rc[7] ? ((rc << 1) ^ 8'h1b) : (rc << 1);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 44; i++) r[1407-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [127:0] rk(input logic [1407:0] e, input int n);
        return e[1407-128*n -: 128];
    endfunction

    function automatic logic [1407:0] model_out();
        logic [1407:0] r;
        r = '0;
        if (m_active) begin
            for (int s = 0; s <= 10; s++) begin
                if (s <= m_cnt) r[1407-128*s -: 128] = m_sched[1407-128*s -: 128];
            end
        end
        return r;
    endfunction

    // Transaction-level model: an accepted start produces a full schedule revealed one round key per edge.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_active = 1'b0;
            m_cnt    = 0;
            m_sched  = '0;
        end else if (start && !(m_active && m_cnt < 10)) begin
            m_sched  = expand(key_in);
            m_active = 1'b1;
            m_cnt    = 0;
        end else if (m_active && m_cnt < 10) begin
            m_cnt++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("cyc_busy", {1407'b0, busy}, {1407'b0, m_active && m_cnt < 10});
        check("cyc_valid", {1407'b0, key_valid}, {1407'b0, m_active && m_cnt == 10});
        check("cyc_exp_key", exp_key, model_out());
    end

    task automatic do_start(input logic [127:0] k);
        @(posedge clk);
        #2;
        start  = 1'b1;
        key_in = k;
        @(posedge clk);
        #2;
        start  = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0]  ka;
        logic [127:0]  kb;
        logic [127:0]  kr;
        logic [1407:0] ea;
        int            busy_cnt;

        build_sbox();
        ka = 128'h000102030405060708090a0b0c0d0e0f;
        kb = 128'h5468617473206D79204B756E67204675;
        ea = expand(ka);

        check("pin_sbox_00", {1400'b0, sb[8'h00]}, {1400'b0, 8'h63});
        check("pin_sbox_53", {1400'b0, sb[8'h53]}, {1400'b0, 8'hed});
        check("pin_model_a_rk1", {1280'b0, rk(ea, 1)}, {1280'b0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe});
        check("pin_model_a_rk10", {1280'b0, rk(ea, 10)}, {1280'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5});

        repeat (3) @(posedge clk);
        #2;
        check("rst_exp_key", exp_key, '0);
        check("rst_busy", {1407'b0, busy}, '0);
        check("rst_valid", {1407'b0, key_valid}, '0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Known-answer key with busy duration and valid latency.
        do_start(ka);
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (i == 10) check("a_valid_at_11", {1407'b0, key_valid}, {1407'b0, 1'b1});
        end
        check("a_busy_cycles", 1408'(busy_cnt), 1408'(10));
        check("a_rk1", {1280'b0, exp_key[1279:1152]}, {1280'b0, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe});
        check("a_rk10", {1280'b0, exp_key[127:0]}, {1280'b0, 128'h13111d7fe3944a17f307a78b4d2b30c5});

        do_start(kb);
        repeat (11) @(negedge clk);
        check("b_rk1", {1280'b0, exp_key[1279:1152]}, {1280'b0, 128'hE232FCF191129188B159E4E6D679A293});
        check("b_rk10", {1280'b0, exp_key[127:0]}, {1280'b0, 128'h28FDDEF86DA4244ACCC0A4FE3B316F26});

        // start mid-expansion is ignored.
        do_start(ka);
        repeat (3) @(posedge clk);
        #2;
        start  = 1'b1;
        key_in = rand128();
        @(posedge clk);
        #2;
        start  = 1'b0;
        repeat (6) @(negedge clk);
        check("ign_not_yet_valid", {1407'b0, key_valid}, '0);
        @(negedge clk);
        check("ign_valid_on_time", {1407'b0, key_valid}, {1407'b0, 1'b1});
        check("ign_full", exp_key, ea);

        // Asynchronous reset mid-expansion.
        do_start(rand128());
        repeat (4) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        check("arst_exp_key", exp_key, '0);
        check("arst_busy", {1407'b0, busy}, '0);
        check("arst_valid", {1407'b0, key_valid}, '0);
        #2;
        n_rst = 1'b1;
        do_start(128'h2b7e151628aed2a6abf7158809cf4f3c);
        repeat (11) @(negedge clk);
        check("c_rk10", {1280'b0, exp_key[127:0]}, {1280'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6});

        // Restart from DONE.
        kr = rand128();
        do_start(kr);
        @(negedge clk);
        check("rs_valid_drop", {1407'b0, key_valid}, '0);
        check("rs_upper_zero", {128'b0, exp_key[1279:0]}, '0);
        repeat (9) @(negedge clk);
        check("rs_not_yet_valid", {1407'b0, key_valid}, '0);
        @(negedge clk);
        check("rs_valid", {1407'b0, key_valid}, {1407'b0, 1'b1});
        check("rs_full", exp_key, expand(kr));

        // Random start pulses with random keys, including during expansion.
        for (int it = 0; it < 25; it++) begin
            do_start(rand128());
            repeat ($urandom_range(1, 16)) begin
                @(posedge clk);
                #2;
                start  = ($urandom_range(0, 3) == 0);
                key_in = rand128();
            end
            start = 1'b0;
        end
        repeat (14) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
